game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Top-level round controller for the LED memory game. Generates a random 16-slot pattern, re-arms
//  and enables the LED pattern printer, then checks the player's button presses against the pattern.
//  Advances the level on success and latches game-over on failure.
//  Sits between the button debouncers and the pattern printer; it owns the printer's enable, reset, level and pattern inputs.
// PARAMETERS
//  LFSR_SEED    16'hACE1   initial LFSR state; a value of 0 is replaced by 16'h0001
//  TIMEOUT_CYC  50000      clk_1 cycles allowed between presses (5 s at 10 kHz)
// PORTS
//  clk_1         in   1   system clock, 10 kHz or faster; the only clock in this block
//  rst           in   1   asynchronous, active-low reset
//  start         in   1   1-cycle pulse: begin a new game
//  btn           in   8   debounced 1-cycle press pulses; bit k means LED k+1
//  print_end     in   1   printer reports that all slots have been shown
//  print_enable  out  1   printer enable
//  print_rst_n   out  1   printer active-low re-arm, 1-cycle low pulse
//  level         out  3   one-hot level: 001, 010, 100
//  pattern_flat  out  48  slot k is pattern_flat[3k+2:3k], k = 0..15
//  round_win     out  1   1-cycle pulse on a completed round
//  game_over     out  1   held high in LOSE
//  score         out  8   saturating score
//  state         out  3   FSM state, for debug
// BEHAVIOUR
//  Reset values: state=IDLE, level=001, score=0, pattern_flat=0, print_enable=0, print_rst_n=1,
//   round_win=0, game_over=0, lfsr=LFSR_SEED.
//  LFSR: 16-bit Galois, taps 16'hB400. Shifts every clk_1 cycle in every state.
//  Sequence length LEN: 8 / 12 / 16 for level 001 / 010 / 100.
//  States: IDLE=0, GEN=1, ARM=2, SHOW=3, WAIT_IN=4, WIN=5, LOSE=6.
//   IDLE: on start, level=001, score=0, idx=0, go to GEN.
//   GEN: 16 cycles. Slot idx <= lfsr[2:0] (post-shift value) and idx++. After slot 15, go to ARM.
//        All 16 slots are written regardless of LEN.
//   ARM: 1 cycle with print_rst_n=0 and print_enable=0, then go to SHOW.
//   SHOW: print_enable=1 until print_end is sampled high.
//         Then print_enable=0, idx=0, timeout counter=0, go to WAIT_IN.
//   WAIT_IN: evaluated each cycle in this priority order:
//    1. btn==0: timeout counter++. When it reaches TIMEOUT_CYC-1, go to LOSE.
//    2. btn not one-hot: go to LOSE.
//    3. encoded btn != slot idx: go to LOSE.
//    4. match: timeout counter=0. If idx==LEN-1, go to WIN; else idx++.
//   WIN: 1 cycle. round_win=1. score += LEN/4, saturating at 255.
//        level shifts left; it stays at 100 once at max. idx=0, go to GEN.
//   LOSE: game_over=1. On start, behave exactly as IDLE+start (game_over clears the next cycle).
//  btn is ignored outside WAIT_IN. start is ignored outside IDLE and LOSE.
//  print_end outside SHOW is ignored.
//  pattern_flat only changes in GEN; it is stable during SHOW and WAIT_IN.
//  rst low at any time, including mid-SHOW: immediate return to the reset values.
//   print_enable drops asynchronously.
//  All outputs are registered; latency from input to output is 1 cycle.
// STRUCTURE
//  Shared package/header game_defs.vh holds:
//   state encodings ST_IDLE..ST_LOSE, LVL_1/LVL_2/LVL_3 one-hot constants, LFSR_TAPS, NUM_SLOTS=16.
//  One sub-module, lfsr16 (clk_1, rst, q[15:0]), is reused by other game blocks.
//  The one-hot-to-3-bit button encoder and valid check are inline combinational logic.
// TESTING
//  1. Reset -> all outputs at their reset values and state=0.
//     Hold start low for 100 cycles -> state stays 0.
//  2. Pulse start -> exactly 16 GEN cycles, then print_rst_n low for 1 cycle,
//     then print_enable=1. pattern_flat matches the LFSR reference model.
//  3. Level 001: assert print_end, then press the 8 correct buttons ->
//     round_win for 1 cycle, level=010, score=2, a new GEN starts.
//  4. Wrong button on the 3rd press -> LOSE, game_over=1.
//     A later start -> game_over=0, level=001, score=0.
//  5. btn=8'b00000101 in WAIT_IN -> LOSE. No press for TIMEOUT_CYC cycles -> LOSE.
//  6. rst low mid-SHOW -> print_enable=0 immediately. Reach level 100 and win -> level stays 100, score +4.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the LED memory game blocks.
// Holds the FSM state codes, the one-hot level constants, the LFSR taps and the
// slot count. It also holds helpers for the LFSR step, the seed fix-up and the
// level-to-length mapping.
package game_sequencer_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_GEN  = 3'd1;
  localparam logic [2:0] ST_ARM  = 3'd2;
  localparam logic [2:0] ST_SHOW = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_WIN  = 3'd5;
  localparam logic [2:0] ST_LOSE = 3'd6;

  localparam logic [2:0] LVL_1 = 3'b001;
  localparam logic [2:0] LVL_2 = 3'b010;
  localparam logic [2:0] LVL_3 = 3'b100;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int unsigned NUM_SLOTS = 16;

  // Right-shifting Galois step: the bit shifted out selects the tap XOR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // An all-zero state would lock the LFSR, so a zero seed is replaced.
  function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] seed);
    lfsr_seed_fix = (seed == 16'h0000) ? 16'h0001 : seed;
  endfunction

  function automatic logic [4:0] seq_len(input logic [2:0] lvl);
    case (lvl)
      LVL_2:   seq_len = 5'd12;
      LVL_3:   seq_len = 5'd16;
      default: seq_len = 5'd8;
    endcase
  endfunction

endpackage

// File: rtl/game_sequencer_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR. It advances every clock and is shared
// by several game blocks.
// Ports: clk_1 (clock), rst (async active-low reset), q (current LFSR state).
module lfsr16
  import game_sequencer_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_1,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) lfsr_q <= lfsr_seed_fix(SEED);
    else      lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: round controller for the LED memory game.
// It fills a 16-slot random pattern, re-arms and enables the pattern printer,
// then checks the player's presses. It advances the level on success and holds
// game-over on failure.
// Ports:
//   clk_1, rst       clock and async active-low reset
//   start            1-cycle pulse, begins a game (in IDLE or LOSE)
//   btn[7:0]         debounced 1-cycle presses; bit k is LED k+1
//   print_end        printer finished showing the pattern
//   print_enable     printer enable
//   print_rst_n      printer re-arm, 1-cycle low pulse
//   level[2:0]       one-hot level
//   pattern_flat     16 slots of 3 bits; slot k at [3k+2:3k]
//   round_win        1-cycle pulse per completed round
//   game_over        high while in LOSE
//   score[7:0]       saturating score
//   state[2:0]       FSM state (debug)
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        clk_1,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  btn,
  input  logic        print_end,
  output logic        print_enable,
  output logic        print_rst_n,
  output logic [2:0]  level,
  output logic [47:0] pattern_flat,
  output logic        round_win,
  output logic        game_over,
  output logic [7:0]  score,
  output logic [2:0]  state
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [15:0]      lfsr_cur;
  logic [15:0]      lfsr_next;

  logic [2:0]       state_q, state_d;
  logic [2:0]       level_q, level_d;
  logic [7:0]       score_q, score_d;
  logic [47:0]      pattern_q, pattern_d;
  logic [3:0]       idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             print_enable_q, print_enable_d;
  logic             print_rst_n_q, print_rst_n_d;
  logic             round_win_q, round_win_d;
  logic             game_over_q, game_over_d;

  logic             btn_onehot;
  logic [2:0]       btn_code;
  logic [5:0]       slot_base;
  logic [2:0]       cur_slot;
  logic [4:0]       len;
  logic [8:0]       score_sum;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_1 (clk_1),
    .rst   (rst),
    .q     (lfsr_cur)
  );

  // GEN stores the value the LFSR takes at this edge, not the one it holds now.
  assign lfsr_next = lfsr_step(lfsr_cur);

  always_comb begin
    btn_code = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (btn[k]) btn_code = 3'(k);
    end
  end

  always_comb begin
    btn_onehot = (btn != '0) && ((btn & (btn - 8'd1)) == '0);
    slot_base  = 6'(idx_q) * 6'd3;
    cur_slot   = pattern_q[slot_base +: 3];
    len        = seq_len(level_q);
    score_sum  = {1'b0, score_q} + 9'(len >> 2);
  end

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    score_d   = score_q;
    pattern_d = pattern_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;

    case (state_q)
      ST_IDLE, ST_LOSE: begin
        if (start) begin
          level_d = LVL_1;
          score_d = '0;
          idx_d   = '0;
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        pattern_d[slot_base +: 3] = lfsr_next[2:0];
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'(NUM_SLOTS - 1)) state_d = ST_ARM;
      end
      ST_ARM: state_d = ST_SHOW;
      ST_SHOW: begin
        if (print_end) begin
          idx_d   = '0;
          tmo_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (btn == '0) begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TMO_W'(TIMEOUT_CYC - 1)) state_d = ST_LOSE;
        end else if (!btn_onehot) begin
          state_d = ST_LOSE;
        end else if (btn_code != cur_slot) begin
          state_d = ST_LOSE;
        end else begin
          tmo_d = '0;
          if (idx_q == 4'(len - 5'd1)) state_d = ST_WIN;
          else                         idx_d   = idx_q + 4'd1;
        end
      end
      ST_WIN: begin
        score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
        level_d = (level_q == LVL_3) ? LVL_3 : (level_q << 1);
        idx_d   = '0;
        state_d = ST_GEN;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flag outputs follow the next state so they align with the state output.
    print_enable_d = (state_d == ST_SHOW);
    print_rst_n_d  = (state_d != ST_ARM);
    round_win_d    = (state_d == ST_WIN);
    game_over_d    = (state_d == ST_LOSE);
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      level_q        <= LVL_1;
      score_q        <= '0;
      pattern_q      <= '0;
      idx_q          <= '0;
      tmo_q          <= '0;
      print_enable_q <= 1'b0;
      print_rst_n_q  <= 1'b1;
      round_win_q    <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      score_q        <= score_d;
      pattern_q      <= pattern_d;
      idx_q          <= idx_d;
      tmo_q          <= tmo_d;
      print_enable_q <= print_enable_d;
      print_rst_n_q  <= print_rst_n_d;
      round_win_q    <= round_win_d;
      game_over_q    <= game_over_d;
    end
  end

  assign state        = state_q;
  assign level        = level_q;
  assign score        = score_q;
  assign pattern_flat = pattern_q;
  assign print_enable = print_enable_q;
  assign print_rst_n  = print_rst_n_q;
  assign round_win    = round_win_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed vectors with an independent LFSR reference.
module tb_game_sequencer;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  btn = '0;
  logic        print_end = 1'b0;
  logic        print_enable, print_rst_n, round_win, game_over;
  logic [2:0]  level, state;
  logic [47:0] pattern_flat;
  logic [7:0]  score;

  int checks = 0;
  int failures = 0;
  logic [15:0] mdl_lfsr;
  logic [47:0] exp_pat;

  game_sequencer #(.LFSR_SEED(16'hACE1), .TIMEOUT_CYC(TMO)) dut (
    .clk_1(clk), .rst(rst_n), .start(start), .btn(btn), .print_end(print_end),
    .print_enable(print_enable), .print_rst_n(print_rst_n), .level(level),
    .pattern_flat(pattern_flat), .round_win(round_win), .game_over(game_over),
    .score(score), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_step(input logic [15:0] c);
    logic [15:0] s;
    s = c >> 1;
    if (c[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mdl_lfsr <= 16'hACE1;
    else        mdl_lfsr <= ref_step(mdl_lfsr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] slot(input int k);
    logic [47:0] p;
    p = exp_pat;
    return p[k*3 +: 3];
  endfunction

  task automatic press(input logic [7:0] b);
    btn = b;
    step();
    btn = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called right after the edge that entered GEN; predicts the pattern from the
  // reference LFSR, then walks GEN, ARM and SHOW.
  task automatic gen_show(input bit do_end);
    logic [15:0] m;
    int n;
    chk("gen_entry_state", 64'(state), 64'(1));
    m = mdl_lfsr;
    exp_pat = '0;
    for (int k = 0; k < 16; k++) begin
      m = ref_step(m);
      exp_pat[k*3 +: 3] = m[2:0];
    end
    n = 0;
    while (state == 3'd1 && n < 40) begin
      step();
      n++;
    end
    chk("gen_cycles", 64'(n), 64'(16));
    chk("arm_state", 64'(state), 64'(2));
    chk("arm_print_rst_n", 64'(print_rst_n), 64'(0));
    chk("arm_print_enable", 64'(print_enable), 64'(0));
    step();
    chk("show_state", 64'(state), 64'(3));
    chk("show_print_enable", 64'(print_enable), 64'(1));
    chk("show_print_rst_n", 64'(print_rst_n), 64'(1));
    chk("pattern", 64'(pattern_flat), 64'(exp_pat));
    btn = 8'h01;
    step();
    btn = '0;
    step();
    chk("show_hold", 64'(state), 64'(3));
    if (do_end) begin
      print_end = 1'b1;
      step();
      print_end = 1'b0;
      chk("wait_state", 64'(state), 64'(4));
      chk("wait_print_enable", 64'(print_enable), 64'(0));
      chk("pattern_stable", 64'(pattern_flat), 64'(exp_pat));
    end
  endtask

  typedef struct {
    logic [2:0] lvl_before;
    int         len;
    logic [2:0] lvl_after;
    logic [7:0] score_after;
  } round_t;

  round_t rounds[4];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] w;
    rounds[0] = '{3'b001, 8,  3'b010, 8'd2};
    rounds[1] = '{3'b010, 12, 3'b100, 8'd5};
    rounds[2] = '{3'b100, 16, 3'b100, 8'd9};
    rounds[3] = '{3'b100, 16, 3'b100, 8'd13};

    repeat (3) step();
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_level", 64'(level), 64'(1));
    chk("rst_score", 64'(score), 64'(0));
    chk("rst_pattern", 64'(pattern_flat), 64'(0));
    chk("rst_print_enable", 64'(print_enable), 64'(0));
    chk("rst_print_rst_n", 64'(print_rst_n), 64'(1));
    chk("rst_round_win", 64'(round_win), 64'(0));
    chk("rst_game_over", 64'(game_over), 64'(0));
    rst_n = 1'b1;
    repeat (100) step();
    chk("idle_hold_state", 64'(state), 64'(0));
    chk("idle_hold_enable", 64'(print_enable), 64'(0));

    pulse_start();
    for (int r = 0; r < 4; r++) begin
      chk("level_before", 64'(level), 64'(rounds[r].lvl_before));
      gen_show(1'b1);
      for (int i = 0; i < rounds[r].len; i++) begin
        press(8'd1 << slot(i));
        if (i < rounds[r].len - 1) begin
          chk("press_stay", 64'(state), 64'(4));
          chk("no_early_win", 64'(round_win), 64'(0));
        end
      end
      chk("win_state", 64'(state), 64'(5));
      chk("round_win", 64'(round_win), 64'(1));
      step();
      chk("after_win_state", 64'(state), 64'(1));
      chk("round_win_pulse", 64'(round_win), 64'(0));
      chk("level_after", 64'(level), 64'(rounds[r].lvl_after));
      chk("score_after", 64'(score), 64'(rounds[r].score_after));
    end

    // Wrong button on the third press.
    gen_show(1'b1);
    press(8'd1 << slot(0));
    press(8'd1 << slot(1));
    w = slot(2) + 3'd1;
    press(8'd1 << w);
    chk("wrong_state", 64'(state), 64'(6));
    chk("wrong_game_over", 64'(game_over), 64'(1));
    btn = 8'h03;
    print_end = 1'b1;
    step();
    btn = '0;
    print_end = 1'b0;
    step();
    chk("lose_hold", 64'(state), 64'(6));
    chk("lose_hold_game_over", 64'(game_over), 64'(1));
    pulse_start();
    chk("restart_game_over", 64'(game_over), 64'(0));
    chk("restart_level", 64'(level), 64'(1));
    chk("restart_score", 64'(score), 64'(0));

    // Two buttons at once.
    gen_show(1'b1);
    press(8'b0000_0101);
    chk("multi_btn_state", 64'(state), 64'(6));

    // Timeout with no presses.
    pulse_start();
    gen_show(1'b1);
    repeat (TMO - 3) step();
    chk("timeout_early", 64'(state), 64'(4));
    repeat (3) step();
    chk("timeout_state", 64'(state), 64'(6));
    chk("timeout_game_over", 64'(game_over), 64'(1));

    // Reset while the printer is enabled.
    pulse_start();
    gen_show(1'b0);
    rst_n = 1'b0;
    #1;
    chk("midshow_enable", 64'(print_enable), 64'(0));
    chk("midshow_state", 64'(state), 64'(0));
    chk("midshow_pattern", 64'(pattern_flat), 64'(0));
    chk("midshow_game_over", 64'(game_over), 64'(0));
    step();
    rst_n = 1'b1;
    print_end = 1'b1;
    btn = 8'h01;
    step();
    print_end = 1'b0;
    btn = '0;
    step();
    chk("idle_ignores_inputs", 64'(state), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
